// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// One conversion per 34 cycles; digits > 9 short-circuit to an error result.
module bcd_to_bin (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [3:0]  unit,
    input  logic [3:0]  ten,
    input  logic [3:0]  hun,
    input  logic [3:0]  tho,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [13:0] data
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StAdj   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] bin_q, bin_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_pend_q, err_pend_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [13:0] data_q, data_d;
    logic        digit_bad;

    assign digit_bad = (unit > 4'd9) || (ten > 4'd9) || (hun > 4'd9) || (tho > 4'd9);

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        err_d      = err_q;
        data_d     = data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    bcd_d = {tho, hun, ten, unit};
                    bin_d = 16'd0;
                    cnt_d = 5'd0;
                    if (digit_bad) begin
                        err_pend_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        err_pend_d = 1'b0;
                        state_d    = StShift;
                    end
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
                cnt_d          = cnt_q + 5'd1;
                state_d        = StAdj;
            end
            StAdj: begin
                // A nibble >= 8 after the shift carries a halved 10, so pull it back by 3.
                for (int i = 0; i < 4; i++) begin
                    if (bcd_q[4*i+3]) begin
                        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] - 4'd3;
                    end
                end
                state_d = (cnt_q == 5'd16) ? StDone : StShift;
            end
            StDone: begin
                done_d  = 1'b1;
                err_d   = err_pend_q;
                // After 16 shifts the whole value sits right-justified in bin_q.
                data_d  = err_pend_q ? 14'd0 : bin_q[13:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            bcd_q      <= 16'd0;
            bin_q      <= 16'd0;
            cnt_q      <= 5'd0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= 14'd0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;
    assign data = data_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: driver pushes expected results, monitor checks on done.
module tb_bcd_to_bin;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [3:0]  unit, ten, hun, tho;
    logic        busy, done, err;
    logic [13:0] data;

    typedef struct {
        logic [13:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    bcd_to_bin dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .unit      (unit),
        .ten       (ten),
        .hun       (hun),
        .tho       (tho),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .data      (data)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue a start at the next rising edge; caller must be at a negedge.
    task automatic issue(input int d3, input int d2, input int d1, input int d0);
        exp_t e;
        bit   bad;
        bad    = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
        e.err  = bad;
        e.data = bad ? 14'd0 : 14'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
        e.due  = cyc + 1 + (bad ? 1 : 33);
        exp_q.push_back(e);
        tho   = 4'(d3);
        hun   = 4'(d2);
        ten   = 4'(d1);
        unit  = 4'(d0);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        // Scramble digits to prove they are only sampled with start.
        {tho, hun, ten, unit} = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge sys_clk);
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge sys_clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (sys_rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data", int'(data), int'(e.data));
                chk("err", int'(err), int'(e.err));
                chk("latency", cyc, e.due);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    initial begin
        int d[4];
        sys_rst_n = 1'b0;
        start     = 1'b0;
        {tho, hun, ten, unit} = 16'h0;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_data", int'(data), 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        issue(9, 9, 9, 9);
        chk("busy_after_start", int'(busy), 1);
        repeat (31) @(negedge sys_clk);
        chk("busy_late", int'(busy), 1);
        wait_idle();
        issue(1, 2, 3, 4);
        wait_idle();
        issue(0, 0, 0, 0);
        wait_idle();
        issue(0, 0, 0, 10);
        wait_idle();
        issue(0, 0, 0, 7);
        wait_idle();

        // Start while busy must be ignored.
        issue(5, 0, 0, 0);
        repeat (8) @(negedge sys_clk);
        {tho, hun, ten, unit} = 16'h1111;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("busy_ignore", int'(busy), 1);

        // Back-to-back: accept a new start in the done cycle.
        for (int i = 0; i < 60 && !done; i++) @(negedge sys_clk);
        chk("b2b_done_seen", int'(done), 1);
        issue(0, 0, 4, 2);
        wait_idle();

        // Reset mid-conversion aborts without a done pulse.
        issue(3, 3, 3, 3);
        repeat (19) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_data", int'(data), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        issue(0, 1, 0, 0);
        wait_idle();

        // Randomized conversions, occasionally with an out-of-range digit or back-to-back.
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 4; k++) begin
                d[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            end
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 60 && exp_q.size() != 0 && !done; i++) @(negedge sys_clk);
            end else begin
                for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge sys_clk);
            end
            while (busy) @(negedge sys_clk);
            issue(d[3], d[2], d[1], d[0]);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
